// File: rtl/rvc_compress_packer.sv
// rvc_compress_packer: streaming RV32 -> RVC compressor.
// Each accepted 32-bit instruction is replaced by its 16-bit RVC form when one
// exists, and the resulting halfwords are packed little-endian into 32-bit words
// behind a one-entry valid/ready output slot.
// Optional build macro RVC_COMPRESS_RV64_EN adds c.ld / c.sd / c.addiw.
module rvc_compress_packer #(
  parameter int unsigned CNT_W  = 16,
  parameter logic [15:0] PAD_HW = 16'h0001
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instr_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic             flush_i,
  output logic [31:0]      data_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic             idle_o,
  output logic [CNT_W-1:0] cnt_compressed_o
);

  typedef enum logic {StEmpty, StHalf} state_e;

  state_e           state_q, state_d;
  logic [15:0]      pend_q, pend_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm_i, imm_s;
  logic        imm6_ok;  // I-immediate fits in a signed 6-bit field

  assign opcode  = instr_i[6:0];
  assign rd      = instr_i[11:7];
  assign funct3  = instr_i[14:12];
  assign rs1     = instr_i[19:15];
  assign rs2     = instr_i[24:20];
  assign funct7  = instr_i[31:25];
  assign imm_i   = instr_i[31:20];
  assign imm_s   = {instr_i[31:25], instr_i[11:7]};
  assign imm6_ok = (&instr_i[31:25]) | ~(|instr_i[31:25]);

  logic        comp;
  logic [15:0] hw;

  // Combinational compressor: comp=1 with hw holding the RVC encoding
  always_comb begin
    comp = 1'b0;
    hw   = 16'h0000;
    case (opcode)
      7'b0010011: begin  // addi
        if (funct3 == 3'b000) begin
          if (rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd0) begin
            comp = 1'b1;
            hw   = 16'h0001;
          end else if (rd != 5'd0 && rs1 == rd && imm_i != 12'd0 && imm6_ok) begin
            comp = 1'b1;
            hw   = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
          end else if (rd != 5'd0 && rs1 == 5'd0 && imm6_ok) begin
            comp = 1'b1;
            hw   = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
          end
        end
      end
      7'b0110011: begin  // add
        if (funct3 == 3'b000 && funct7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0) begin
          if (rs1 == 5'd0) begin
            comp = 1'b1;
            hw   = {4'b1000, rd, rs2, 2'b10};
          end else if (rs1 == rd) begin
            comp = 1'b1;
            hw   = {4'b1001, rd, rs2, 2'b10};
          end
        end
      end
      7'b0000011: begin  // loads
        if (funct3 == 3'b010 && rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
            imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00) begin
          comp = 1'b1;
          hw   = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end
`ifdef RVC_COMPRESS_RV64_EN
        else if (funct3 == 3'b011 && rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
                 imm_i[11:8] == 4'd0 && imm_i[2:0] == 3'b000) begin
          comp = 1'b1;
          hw   = {3'b011, imm_i[5:3], rs1[2:0], imm_i[7:6], rd[2:0], 2'b00};
        end
`endif
      end
      7'b0100011: begin  // stores
        if (funct3 == 3'b010 && rs2[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
            imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00) begin
          comp = 1'b1;
          hw   = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end
`ifdef RVC_COMPRESS_RV64_EN
        else if (funct3 == 3'b011 && rs2[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
                 imm_s[11:8] == 4'd0 && imm_s[2:0] == 3'b000) begin
          comp = 1'b1;
          hw   = {3'b111, imm_s[5:3], rs1[2:0], imm_s[7:6], rs2[2:0], 2'b00};
        end
`endif
      end
      7'b1100111: begin  // jalr
        if (funct3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0) begin
          if (rd == 5'd0) begin
            comp = 1'b1;
            hw   = {4'b1000, rs1, 5'd0, 2'b10};
          end else if (rd == 5'd1) begin
            comp = 1'b1;
            hw   = {4'b1001, rs1, 5'd0, 2'b10};
          end
        end
      end
      7'b1110011: begin  // ebreak
        if (instr_i == 32'h0010_0073) begin
          comp = 1'b1;
          hw   = 16'h9002;
        end
      end
`ifdef RVC_COMPRESS_RV64_EN
      7'b0011011: begin  // addiw
        if (funct3 == 3'b000 && rd != 5'd0 && rs1 == rd && imm6_ok) begin
          comp = 1'b1;
          hw   = {3'b001, imm_i[5], rd, imm_i[4:0], 2'b01};
        end
      end
`endif
      default: ;
    endcase
  end

  logic in_fire, out_fire;
  assign instr_ready_o = !valid_q || data_ready_i;
  assign in_fire       = instr_valid_i && instr_ready_o;
  assign out_fire      = valid_q && data_ready_i;

  // Packing FSM: next state, pending halfword and output slot
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    data_d  = data_q;
    valid_d = out_fire ? 1'b0 : valid_q;
    if (in_fire) begin
      if (state_q == StEmpty) begin
        if (comp) begin
          pend_d  = hw;
          state_d = StHalf;
        end else begin
          data_d  = instr_i;
          valid_d = 1'b1;
        end
      end else if (comp) begin
        data_d  = {hw, pend_q};
        valid_d = 1'b1;
        state_d = StEmpty;
      end else begin
        data_d  = {instr_i[15:0], pend_q};
        pend_d  = instr_i[31:16];
        valid_d = 1'b1;
      end
    end else if (state_q == StHalf && flush_i && instr_ready_o) begin
      // Flush only when the slot is free or draining this cycle
      data_d  = {PAD_HW, pend_q};
      valid_d = 1'b1;
      state_d = StEmpty;
    end
  end

  // State, slot and saturating counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      pend_q  <= 16'h0000;
      data_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      if (in_fire && comp && cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign data_o           = data_q;
  assign data_valid_o     = valid_q;
  assign idle_o           = (state_q == StEmpty) && !valid_q;
  assign cnt_compressed_o = cnt_q;

endmodule

// File: tb/tb_rvc_compress_packer.sv
// Directed self-checking bench for rvc_compress_packer.
module tb_rvc_compress_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        idle;
  logic [15:0] cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  rvc_compress_packer #(
    .CNT_W (16),
    .PAD_HW(16'h0001)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .instr_i         (instr),
    .instr_valid_i   (instr_valid),
    .instr_ready_o   (instr_ready),
    .flush_i         (flush),
    .data_o          (data),
    .data_valid_o    (data_valid),
    .data_ready_i    (data_ready),
    .idle_o          (idle),
    .cnt_compressed_o(cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Present one word, wait (bounded) for ready, complete the handshake
  task automatic send(input logic [31:0] w);
    int n;
    instr       = w;
    instr_valid = 1'b1;
    #1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!instr_ready) check_eq("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  typedef struct {
    logic [31:0] w;
    logic        c;
    logic [15:0] hw;
  } vec_t;

  vec_t vecs[13] = '{
    '{32'hFFD00293, 1'b1, 16'h52F5},  // addi x5,x0,-3 -> c.li
    '{32'hFE050513, 1'b1, 16'h1501},  // addi x10,x10,-32 -> c.addi
    '{32'h00B00533, 1'b1, 16'h852E},  // add x10,x0,x11 -> c.mv
    '{32'h00B50533, 1'b1, 16'h952E},  // add x10,x10,x11 -> c.add
    '{32'h00442483, 1'b1, 16'h4044},  // lw x9,4(x8) -> c.lw
    '{32'h06942E23, 1'b1, 16'hDC64},  // sw x9,124(x8) -> c.sw
    '{32'h00008067, 1'b1, 16'h8082},  // jalr x0,x1,0 -> c.jr
    '{32'h000280E7, 1'b1, 16'h9282},  // jalr x1,x5,0 -> c.jalr
    '{32'h00100073, 1'b1, 16'h9002},  // ebreak
    '{32'h02050513, 1'b0, 16'h0000},  // addi x10,x10,32: imm out of range
    '{32'h08042483, 1'b0, 16'h0000},  // lw x9,128(x8): offset too large
    '{32'h00242483, 1'b0, 16'h0000},  // lw x9,2(x8): misaligned offset
    '{32'h00100013, 1'b0, 16'h0000}   // addi x0,x0,1: hint, not c.nop
  };

  initial begin
    rst         = 1'b1;
    instr       = 32'h0;
    instr_valid = 1'b0;
    flush       = 1'b0;
    data_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_eq("rst_valid", {31'd0, data_valid}, 32'd0);
    check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
    check_eq("rst_idle", {31'd0, idle}, 32'd1);
    check_eq("rst_cnt", {16'd0, cnt}, 32'd0);
    check_eq("rst_data", data, 32'd0);

    // Two c.addi packed into one word
    send(32'h00150513);
    exp_cnt++;
    check_eq("half_novalid", {31'd0, data_valid}, 32'd0);
    check_eq("half_notidle", {31'd0, idle}, 32'd0);
    send(32'hFFF58593);
    exp_cnt++;
    check_eq("pair_valid", {31'd0, data_valid}, 32'd1);
    check_eq("pair_data", data, 32'h15FD0505);
    check_eq("pair_cnt", {16'd0, cnt}, exp_cnt);
    tick();
    check_eq("pair_idle", {31'd0, idle}, 32'd1);

    // Uncompressible from EMPTY passes verbatim
    send(32'h123452B7);
    check_eq("lui_valid", {31'd0, data_valid}, 32'd1);
    check_eq("lui_data", data, 32'h123452B7);
    tick();
    check_eq("lui_idle", {31'd0, idle}, 32'd1);

    // c.nop then lui straddles words, then flush pads
    send(32'h00000013);
    exp_cnt++;
    send(32'h123452B7);
    check_eq("straddle_data", data, 32'h52B70001);
    check_eq("straddle_half", {31'd0, idle}, 32'd0);
    do_flush();
    check_eq("flush_valid", {31'd0, data_valid}, 32'd1);
    check_eq("flush_data", data, 32'h00011234);
    tick();
    check_eq("flush_idle", {31'd0, idle}, 32'd1);

    // Backpressure: slot held, input stalled
    data_ready = 1'b0;
    send(32'h123452B7);
    instr       = 32'h00000013;
    instr_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_ready", {31'd0, instr_ready}, 32'd0);
      check_eq("bp_data", data, 32'h123452B7);
      check_eq("bp_valid", {31'd0, data_valid}, 32'd1);
      tick();
    end
    data_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    exp_cnt++;
    check_eq("bp_drained", {31'd0, data_valid}, 32'd0);
    check_eq("bp_half", {31'd0, idle}, 32'd0);
    check_eq("bp_cnt", {16'd0, cnt}, exp_cnt);
    do_flush();
    check_eq("bp_flush_data", data, 32'h00010001);
    tick();
    check_eq("bp_idle", {31'd0, idle}, 32'd1);

    // Reset while HALF discards the pending halfword
    send(32'h00150513);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    check_eq("mrst_idle", {31'd0, idle}, 32'd1);
    check_eq("mrst_cnt", {16'd0, cnt}, 32'd0);
    send(32'h123452B7);
    check_eq("mrst_data", data, 32'h123452B7);
    tick();

    // Encoding table: compressible ones paired with a trailing c.nop
    foreach (vecs[k]) begin
      send(vecs[k].w);
      if (vecs[k].c) begin
        exp_cnt++;
        check_eq("vec_hold", {31'd0, data_valid}, 32'd0);
        send(32'h00000013);
        exp_cnt++;
        check_eq($sformatf("vec%0d_comp", k), data, {16'h0001, vecs[k].hw});
      end else begin
        check_eq($sformatf("vec%0d_pass", k), data, vecs[k].w);
      end
      tick();
    end
    check_eq("table_cnt", {16'd0, cnt}, exp_cnt);
    check_eq("table_idle", {31'd0, idle}, 32'd1);

    // ld x8,8(x9)
    send(32'h0084B403);
`ifdef RVC_COMPRESS_RV64_EN
    check_eq("ld_hold", {31'd0, data_valid}, 32'd0);
    do_flush();
    check_eq("ld_flush_data", data, 32'h00016480);
`else
    check_eq("ld_pass", data, 32'h0084B403);
    do_flush();
    check_eq("ld_flush_none", {31'd0, data_valid}, 32'd0);
    check_eq("ld_flush_idle", {31'd0, idle}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
